// File: rtl/ifb_pkg.sv
// Shared types and sizing for the instruction fetch buffer.
// The optional fault tracking is enabled with the IFB_FAULT_EN macro.
package ifb_pkg;

  localparam int IFB_ADDR_W = 32;
  localparam int IFB_INSN_W = 32;
  localparam int IFB_DEPTH  = 4;
  localparam int IFB_PTR_W  = $clog2(IFB_DEPTH);

`ifdef IFB_FAULT_EN
  // Each queued entry carries one extra bit flagging a misaligned fetch PC.
  localparam int IFB_FAULT_W = 1;
`else
  localparam int IFB_FAULT_W = 0;
`endif

  // Logical layout of one queued fetch result at the default widths.
  typedef struct packed {
    logic [IFB_ADDR_W-1:0] pc;
    logic [IFB_INSN_W-1:0] insn;
    logic                  fault;
  } ifb_entry_t;

  // A PC whose low two bits are non-zero cannot address a whole instruction word.
  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return |pc_lo;
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Show-ahead register FIFO holding fetched {pc, insn[, fault]} entries.
// The head is visible combinationally; when empty the last head value is held.
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int W     = IFB_ADDR_W + IFB_INSN_W + IFB_FAULT_W,
  parameter int DEPTH = IFB_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [W-1:0]             head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [W-1:0]     hold;

  // Pointer and occupancy bookkeeping; clear returns everything to the empty state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  // NOTE: the storage array has no reset -- occupancy is tracked by count, so stale data is never exposed.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  // Remember the most recent head so the outputs stay stable once the queue drains.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold <= '0;
    end else if (count != '0) begin
      hold <= mem[rd_ptr];
    end
  end

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : hold;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: accepts PCs, reads a 1-cycle synchronous instruction
// memory and queues {pc, insn} pairs for decode. Credit-based backpressure means the
// queue can never overflow. Flush discards queued and in-flight fetches.
// Optional macro IFB_FAULT_EN adds a per-entry insn_fault flag for misaligned PCs.
module instr_fetch_buffer
  import ifb_pkg::*;
#(
  parameter int ADDR_W = IFB_ADDR_W,
  parameter int INSN_W = IFB_INSN_W,
  parameter int DEPTH  = IFB_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_en,
  output logic [ADDR_W-3:0] imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [INSN_W-1:0] insn_out,
  output logic [ADDR_W-1:0] insn_pc_out,
  output logic              insn_valid,
  input  logic              insn_ready
`ifdef IFB_FAULT_EN
  ,
  output logic              insn_fault
`endif
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSN_W + IFB_FAULT_W;

  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   used;
  logic               accept;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;
  logic               head_valid;

`ifdef IFB_FAULT_EN
  logic               inflight_fault;
`endif

  // A slot is reserved for the in-flight fetch, so credit counts it alongside queued entries.
  // pc_ready is also gated by reset_n so nothing is offered while reset is held.
  assign used     = count + CNT_W'(inflight);
  assign pc_ready = reset_n & ~flush & (used < CNT_W'(DEPTH));
  assign accept   = pc_valid & pc_ready;

  assign imem_en   = accept;
  assign imem_addr = pc_in[ADDR_W-1:2];

  // Track the single outstanding memory read; a flush cancels it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (flush) begin
      inflight    <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) inflight_pc <= pc_in;
    end
  end

`ifdef IFB_FAULT_EN
  // Misalignment is captured with the PC and carried into the queue entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_fault <= 1'b0;
    end else if (accept) begin
      inflight_fault <= is_misaligned(pc_in[1:0]);
    end
  end

  assign push_data = {inflight_pc, (inflight_fault ? '0 : imem_rdata), inflight_fault};
  assign insn_fault = head_data[0];
`else
  assign push_data = {inflight_pc, imem_rdata};
`endif

  // Returning data is dropped in a flush cycle; decode cannot pop during a flush either.
  assign push = inflight & ~flush;
  assign pop  = head_valid & insn_ready & ~flush;

  ifb_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .clear      (flush),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (count)
  );

  assign insn_valid  = head_valid;
  assign insn_pc_out = head_data[ENTRY_W-1 -: ADDR_W];
  assign insn_out    = head_data[ENTRY_W-ADDR_W-1 -: INSN_W];

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based model of the fetch buffer. Honours IFB_FAULT_EN when defined.
module tb_instr_fetch_buffer;

  localparam int ADDR_W = 32;
  localparam int INSN_W = 32;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;
  logic              imem_en;
  logic [ADDR_W-3:0] imem_addr;
  logic [INSN_W-1:0] imem_rdata = '0;
  logic [INSN_W-1:0] insn_out;
  logic [ADDR_W-1:0] insn_pc_out;
  logic              insn_valid;
  logic              insn_ready;
`ifdef IFB_FAULT_EN
  logic              insn_fault;
`endif

  int total = 0;
  int bad   = 0;

  instr_fetch_buffer #(.ADDR_W(ADDR_W), .INSN_W(INSN_W), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .insn_out    (insn_out),
    .insn_pc_out (insn_pc_out),
    .insn_valid  (insn_valid),
    .insn_ready  (insn_ready)
`ifdef IFB_FAULT_EN
    ,
    .insn_fault  (insn_fault)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [29:0] w);
    return 32'hC0DE_0000 ^ ({2'b00, w} * 32'h9E37_79B1);
  endfunction

  function automatic bit fault_of(input logic [31:0] pc);
`ifdef IFB_FAULT_EN
    return pc[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    logic [31:0] p;
    p = pc;
    return fault_of(p) ? 32'h0 : mem_word(p[31:2]);
  endfunction

  // Synchronous instruction memory, one cycle read latency.
  always @(posedge clock) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  logic [31:0] pend_pc   = '0;
  bit          pend      = 1'b0;
  logic [31:0] last_pc   = '0;
  logic [31:0] last_insn = '0;
  bit          last_flt  = 1'b0;

  always @(negedge clock) begin : compare
    bit          exp_ready;
    bit          exp_en;
    bit          exp_valid;
    logic [31:0] head;
    if (!reset_n) begin
      mq.delete();
      pend      = 1'b0;
      last_pc   = '0;
      last_insn = '0;
      last_flt  = 1'b0;
      check("rst_insn_valid", insn_valid, 0);
      check("rst_pc_ready", pc_ready, 0);
      check("rst_imem_en", imem_en, 0);
      check("rst_insn_out", insn_out, 0);
      check("rst_insn_pc_out", insn_pc_out, 0);
`ifdef IFB_FAULT_EN
      check("rst_insn_fault", insn_fault, 0);
`endif
    end else begin
      exp_ready = !flush && (mq.size() + int'(pend) < DEPTH);
      exp_en    = pc_valid && exp_ready;
      exp_valid = mq.size() != 0;
      if (exp_valid) begin
        head      = mq[0];
        last_pc   = head;
        last_insn = insn_of(head);
        last_flt  = fault_of(head);
      end
      check("pc_ready", pc_ready, exp_ready);
      check("imem_en", imem_en, exp_en);
      if (exp_en) check("imem_addr", imem_addr, pc_in[31:2]);
      check("insn_valid", insn_valid, exp_valid);
      check("insn_pc_out", insn_pc_out, last_pc);
      check("insn_out", insn_out, last_insn);
`ifdef IFB_FAULT_EN
      check("insn_fault", insn_fault, last_flt);
`endif
      // Advance the model across the coming edge.
      if (flush) begin
        mq.delete();
        pend = 1'b0;
      end else begin
        if (exp_valid && insn_ready) void'(mq.pop_front());
        if (pend) mq.push_back(pend_pc);
        pend    = exp_en;
        pend_pc = pc_in;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v, input logic [31:0] pc, input bit rdy, input bit fl, output bit acc);
    pc_valid   = v;
    pc_in      = pc;
    insn_ready = rdy;
    flush      = fl;
    @(negedge clock);
    acc = pc_valid && pc_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit          acc;
    bit          found;
    logic [31:0] pc;
    int          n;

    pc_valid = 1'b0; pc_in = '0; insn_ready = 1'b0; flush = 1'b0;
    #1 reset_n = 1'b0;
    @(negedge clock);
    check("t0_reset_ready", pc_ready, 0);
    check("t0_reset_valid", insn_valid, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // 1: back-to-back fetch of 0,4,8 with decode always ready.
    pc_valid = 1'b1; pc_in = 32'h0; insn_ready = 1'b1;
    @(negedge clock);
    check("t1_addr0", imem_addr, 0);
    check("t1_en0", imem_en, 1);
    check("t1_valid0", insn_valid, 0);
    next_cycle(); pc_in = 32'h4;
    @(negedge clock);
    check("t1_addr1", imem_addr, 1);
    check("t1_valid1", insn_valid, 0);
    next_cycle(); pc_in = 32'h8;
    @(negedge clock);
    check("t1_addr2", imem_addr, 2);
    check("t1_valid2", insn_valid, 1);
    check("t1_pc0", insn_pc_out, 32'h0);
    check("t1_insn0", insn_out, mem_word(30'd0));
    next_cycle(); pc_valid = 1'b0;
    @(negedge clock);
    check("t1_pc4", insn_pc_out, 32'h4);
    check("t1_insn1", insn_out, mem_word(30'd1));
    next_cycle();
    @(negedge clock);
    check("t1_pc8", insn_pc_out, 32'h8);
    check("t1_insn2", insn_out, mem_word(30'd2));
    next_cycle();
    @(negedge clock);
    check("t1_empty", insn_valid, 0);
    check("t1_hold_pc", insn_pc_out, 32'h8);
    next_cycle();

    // 2: decode stalled -> exactly DEPTH accepted, then release.
    pc = 32'h10; n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pc, 1'b0, 1'b0, acc);
      if (acc) begin pc += 4; n++; end
    end
    check("t2_accepted", n, 4);
    check("t2_next_pc", pc, 32'h20);
    step(1'b1, pc, 1'b1, 1'b0, acc);
    check("t2_no_credit_yet", acc, 0);
    step(1'b1, pc, 1'b1, 1'b0, acc);
    check("t2_credit_back", acc, 1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, acc);

    // 3: flush with two entries queued and one fetch in flight.
    step(1'b1, 32'h200, 1'b0, 1'b0, acc);
    step(1'b1, 32'h204, 1'b0, 1'b0, acc);
    step(1'b1, 32'h40, 1'b0, 1'b0, acc);
    check("t3_acc40", acc, 1);
    step(1'b1, 32'h300, 1'b0, 1'b1, acc);
    check("t3_flush_no_accept", acc, 0);
    pc_valid = 1'b1; pc_in = 32'h100; insn_ready = 1'b1; flush = 1'b0;
    @(negedge clock);
    check("t3_valid_after_flush", insn_valid, 0);
    check("t3_ready_after_flush", pc_ready, 1);
    next_cycle();
    pc_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clock);
      if (insn_valid) begin
        found = 1'b1;
        check("t3_first_pc", insn_pc_out, 32'h100);
      end
      next_cycle();
    end
    check("t3_seen", found, 1);

    // 4: full queue, then sustained ready/valid across pointer wrap.
    pc = 32'h1000;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pc, 1'b0, 1'b0, acc);
      if (acc) pc += 4;
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, pc, 1'b1, 1'b0, acc);
      if (acc) pc += 4;
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, acc);

    // 5: asynchronous reset pulse mid-stream.
    pc = 32'h2000;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pc, 1'b0, 1'b0, acc);
      if (acc) pc += 4;
    end
    #2 reset_n = 1'b0;
    #1;
    check("t5_valid_drop", insn_valid, 0);
    check("t5_ready_drop", pc_ready, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    step(1'b1, 32'h500, 1'b1, 1'b0, acc);
    check("t5_acc500", acc, 1);
    pc_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clock);
      if (insn_valid) begin
        found = 1'b1;
        check("t5_first_pc", insn_pc_out, 32'h500);
      end
      next_cycle();
    end
    check("t5_seen", found, 1);

    // 6: misaligned PC 0x22.
    step(1'b1, 32'h22, 1'b0, 1'b0, acc);
    pc_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clock);
      if (insn_valid) begin
        found = 1'b1;
        check("t6_pc", insn_pc_out, 32'h22);
`ifdef IFB_FAULT_EN
        check("t6_fault", insn_fault, 1);
        check("t6_insn_zero", insn_out, 0);
`else
        check("t6_insn_word8", insn_out, mem_word(30'd8));
`endif
      end
      next_cycle();
    end
    check("t6_seen", found, 1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, acc);

    // Randomized traffic with occasional flushes and misaligned PCs.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
